// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART image loader that streams a checksummed program into ICCM
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   prog_i               level request to enter/stay in programming mode
//   rx_dv_i, rx_byte_i   one-cycle strobe and byte from the UART receiver
//   we_o, addr_o,        one-cycle ICCM word write strobe, word address, data
//   wdata_o
//   reset_o              active-low hold of the core/ICCM adapter while loading
//   done_o, err_o        image loaded with good checksum / load failed
//
// Stream format: count N (2 bytes, LE), N words (4 bytes each, LE), then one
// byte equal to the XOR of all payload bytes.

module prog_loader #(
  parameter int MAX_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        prog_i,
  input  logic        rx_dv_i,
  input  logic [7:0]  rx_byte_i,
  output logic        we_o,
  output logic [11:0] addr_o,
  output logic [31:0] wdata_o,
  output logic        reset_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  state_t         state, state_next;
  logic [15:0]    word_cnt;
  logic [11:0]    word_addr;
  logic [1:0]     byte_cnt;
  logic [23:0]    asm_word;
  logic [7:0]     xor_r;
  logic [TW-1:0]  tmo;

  logic           loading;
  logic           accept;
  logic           tmo_hit;
  logic           last_word;
  logic [15:0]    hdr_n;

  assign loading   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign accept    = loading && prog_i && rx_dv_i;
  // The limit fires on the edge where the idle count would reach TIMEOUT_CYC;
  // a byte on that same cycle takes priority.
  assign tmo_hit   = loading && !rx_dv_i && (tmo == TW'(TIMEOUT_CYC - 1));
  assign hdr_n     = {rx_byte_i, word_cnt[7:0]};
  assign last_word = (({4'd0, word_addr} + 16'd1) == word_cnt);

  assign reset_o = (state == IDLE) || (state == DONE);
  assign done_o  = (state == DONE);
  assign err_o   = (state == ERR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (prog_i) state_next = HDR0;
      HDR0: begin
        if (!prog_i)      state_next = IDLE;
        else if (rx_dv_i) state_next = HDR1;
        else if (tmo_hit) state_next = ERR;
      end
      HDR1: begin
        if (!prog_i) state_next = IDLE;
        else if (rx_dv_i) begin
          if ((hdr_n == 16'd0) || (hdr_n > 16'(MAX_WORDS))) state_next = ERR;
          else                                              state_next = DATA;
        end
        else if (tmo_hit) state_next = ERR;
      end
      DATA: begin
        if (!prog_i) state_next = IDLE;
        else if (rx_dv_i) begin
          // Leave for CSUM as the final word is captured; its write pulse
          // then lands in the first CSUM cycle.
          if ((byte_cnt == 2'd3) && last_word) state_next = CSUM;
        end
        else if (tmo_hit) state_next = ERR;
      end
      CSUM: begin
        if (!prog_i) state_next = IDLE;
        else if (rx_dv_i) state_next = (rx_byte_i == xor_r) ? DONE : ERR;
        else if (tmo_hit) state_next = ERR;
      end
      DONE, ERR: if (!prog_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      we_o      <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
      word_cnt  <= '0;
      word_addr <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      xor_r     <= '0;
      tmo       <= '0;
    end else begin
      state <= state_next;
      we_o  <= 1'b0;

      if ((state_next != state) || rx_dv_i || !loading) tmo <= '0;
      else                                               tmo <= tmo + TW'(1);

      if ((state == IDLE) && (state_next == HDR0)) begin
        xor_r    <= '0;
        byte_cnt <= '0;
      end

      if (accept) begin
        case (state)
          HDR0: word_cnt[7:0] <= rx_byte_i;
          HDR1: begin
            word_cnt[15:8] <= rx_byte_i;
            word_addr      <= '0;
          end
          DATA: begin
            xor_r    <= xor_r ^ rx_byte_i;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= rx_byte_i;
              2'd1: asm_word[15:8]  <= rx_byte_i;
              2'd2: asm_word[23:16] <= rx_byte_i;
              default: begin
                // Write stage owns its own copy, so the next byte can start
                // assembling while this word is being written.
                we_o      <= 1'b1;
                addr_o    <= word_addr;
                wdata_o   <= {rx_byte_i, asm_word};
                word_addr <= word_addr + 12'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader

module tb_prog_loader;

  localparam int T    = 40;
  localparam int MAXW = 1024;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        prog_i = 1'b0;
  logic        rx_dv_i = 1'b0;
  logic [7:0]  rx_byte_i = 8'h00;
  logic        we_o;
  logic [11:0] addr_o;
  logic [31:0] wdata_o;
  logic        reset_o;
  logic        done_o;
  logic        err_o;

  prog_loader #(.MAX_WORDS(MAXW), .TIMEOUT_CYC(T)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .prog_i    (prog_i),
    .rx_dv_i   (rx_dv_i),
    .rx_byte_i (rx_byte_i),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .wdata_o   (wdata_o),
    .reset_o   (reset_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  logic [43:0] exp_q[$];
  logic [7:0]  stream[$];
  logic [43:0] e;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write pulse must match the next write the model predicted.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_we: got addr %0h data %0h expected no write", addr_o, wdata_o);
        end else begin
          e = exp_q.pop_front();
          check("we_addr", {32'd0, addr_o}, {32'd0, e[43:32]});
          check("we_data", {12'd0, wdata_o}, {12'd0, e[31:0]});
        end
      end
      if (done_o) check("done_reset_o", {43'd0, reset_o}, 44'd1);
      if (err_o)  check("err_reset_o",  {43'd0, reset_o}, 44'd0);
    end
  end

  // Protocol model over the byte stream: queues the writes it implies and
  // returns 0 = still loading, 1 = done, 2 = error.
  function automatic int model_load();
    int n, avail, words;
    logic [7:0] x;
    if (stream.size() < 2) return 0;
    n = int'({stream[1], stream[0]});
    if (n == 0 || n > MAXW) return 2;
    avail = stream.size() - 2;
    words = avail / 4;
    if (words > n) words = n;
    for (int i = 0; i < words; i++)
      exp_q.push_back({12'(i), stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]});
    if (avail < 4*n + 1) return 0;
    x = 8'h00;
    for (int i = 0; i < 4*n; i++) x ^= stream[2+i];
    return (stream[2+4*n] == x) ? 1 : 2;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic put_hdr(input int n);
    logic [15:0] v;
    v = 16'(n);
    stream.push_back(v[7:0]);
    stream.push_back(v[15:8]);
  endtask

  task automatic put_word(input logic [31:0] w);
    stream.push_back(w[7:0]);
    stream.push_back(w[15:8]);
    stream.push_back(w[23:16]);
    stream.push_back(w[31:24]);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx_dv_i   = 1'b1;
      rx_byte_i = stream[i];
      tick(1);
    end
    rx_dv_i = 1'b0;
  endtask

  task automatic start_prog();
    prog_i = 1'b1;
    tick(1);
    check("reset_o_loading", {43'd0, reset_o}, 44'd0);
  endtask

  task automatic finish_prog(input string name);
    prog_i = 1'b0;
    tick(1);
    check({name, "_idle_reset_o"}, {43'd0, reset_o}, 44'd1);
    check({name, "_idle_flags"}, {42'd0, done_o, err_o}, 44'd0);
    tick(1);
  endtask

  task automatic run_case(input string name, input int o);
    start_prog();
    send_range(0, stream.size());
    tick(3);
    check({name, "_done"},    {43'd0, done_o},  {43'd0, o == 1});
    check({name, "_err"},     {43'd0, err_o},   {43'd0, o == 2});
    check({name, "_reset_o"}, {43'd0, reset_o}, {43'd0, o != 2});
    check({name, "_writes_left"}, 44'(exp_q.size()), 44'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  initial begin
    int o;
    logic [7:0] x;
    logic [31:0] w;

    // Reset values
    tick(2);
    check("rst_reset_o", {43'd0, reset_o}, 44'd1);
    check("rst_we",      {43'd0, we_o},    44'd0);
    check("rst_addr",    {32'd0, addr_o},  44'd0);
    check("rst_wdata",   {12'd0, wdata_o}, 44'd0);
    check("rst_flags",   {42'd0, done_o, err_o}, 44'd0);
    rst_ni = 1'b1;
    tick(1);

    // Bytes with prog_i low are ignored
    stream.delete();
    put_hdr(1);
    put_word(32'h01020304);
    send_range(0, stream.size());
    tick(2);
    check("idle_ignore_reset_o", {43'd0, reset_o}, 44'd1);
    check("idle_ignore_flags", {42'd0, done_o, err_o}, 44'd0);

    // Good two-word image; payload XOR is 0x2A
    stream.delete();
    put_hdr(2);
    put_word(32'h12345678);
    put_word(32'hDEADBEEF);
    stream.push_back(8'h2A);
    o = model_load();
    check("model_good_outcome", 44'(o), 44'd1);
    check("model_w0", exp_q[0], {12'd0, 32'h12345678});
    check("model_w1", exp_q[1], {12'd1, 32'hDEADBEEF});
    run_case("good", o);
    stream.delete();
    stream.push_back(8'h55);
    send_range(0, 1);
    tick(2);
    check("done_hold", {43'd0, done_o}, 44'd1);
    finish_prog("good");

    // Same payload, wrong checksum: both writes, then error held until prog_i drops
    stream.delete();
    put_hdr(2);
    put_word(32'h12345678);
    put_word(32'hDEADBEEF);
    stream.push_back(8'h01);
    o = model_load();
    check("model_bad_outcome", 44'(o), 44'd2);
    run_case("badcsum", o);
    tick(10);
    check("err_hold", {43'd0, err_o}, 44'd1);
    check("err_hold_reset_o", {43'd0, reset_o}, 44'd0);
    finish_prog("badcsum");

    // Illegal word counts
    stream.delete();
    put_hdr(0);
    o = model_load();
    run_case("n0", o);
    finish_prog("n0");
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h04);
    o = model_load();
    check("model_n1025_outcome", 44'(o), 44'd2);
    run_case("n1025", o);
    finish_prog("n1025");

    // Largest legal image: addresses 0..1023
    stream.delete();
    put_hdr(MAXW);
    x = 8'h00;
    for (int i = 0; i < MAXW; i++) begin
      w = 32'(i) * 32'h9E3779B1;
      put_word(w);
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    stream.push_back(x);
    o = model_load();
    check("model_max_last", exp_q[MAXW-1], {12'd1023, 32'(1023) * 32'h9E3779B1});
    run_case("nmax", o);
    finish_prog("nmax");

    // Silence of T cycles after payload bytes -> error
    stream.delete();
    put_hdr(1);
    stream.push_back(8'h11);
    stream.push_back(8'h22);
    o = model_load();
    start_prog();
    send_range(0, stream.size());
    tick(T - 1);
    check("tmo_before_limit", {43'd0, err_o}, 44'd0);
    tick(1);
    check("tmo_at_limit", {43'd0, err_o}, 44'd1);
    check("tmo_reset_o", {43'd0, reset_o}, 44'd0);
    finish_prog("tmo");

    // Byte arriving on the limit cycle wins; load then completes
    stream.delete();
    put_hdr(1);
    put_word(32'h44332211);
    stream.push_back(8'h44);
    o = model_load();
    check("model_tmo_w0", exp_q[0], {12'd0, 32'h44332211});
    check("model_tmo_outcome", 44'(o), 44'd1);
    start_prog();
    send_range(0, 4);
    tick(T - 1);
    send_range(4, stream.size());
    tick(3);
    check("limit_byte_err", {43'd0, err_o}, 44'd0);
    check("limit_byte_done", {43'd0, done_o}, 44'd1);
    check("limit_byte_writes_left", 44'(exp_q.size()), 44'd0);
    finish_prog("limit");

    // Abort after 5 payload bytes: exactly one write
    stream.delete();
    put_hdr(2);
    put_word(32'hA1B2C3D4);
    stream.push_back(8'h99);
    o = model_load();
    check("model_abort_writes", 44'(exp_q.size()), 44'd1);
    start_prog();
    send_range(0, stream.size());
    prog_i = 1'b0;
    tick(1);
    check("abort_reset_o", {43'd0, reset_o}, 44'd1);
    check("abort_flags", {42'd0, done_o, err_o}, 44'd0);
    check("abort_writes_left", 44'(exp_q.size()), 44'd0);
    tick(2);

    // Asynchronous reset mid-DATA, then a clean N=1 load at addr 0
    stream.delete();
    put_hdr(3);
    put_word(32'h0BADF00D);
    put_word(32'h87654321);
    stream.push_back(8'h77);
    stream.push_back(8'h66);
    o = model_load();
    start_prog();
    send_range(0, stream.size());
    #2;
    rst_ni = 1'b0;
    prog_i = 1'b0;
    #1;
    check("arst_reset_o", {43'd0, reset_o}, 44'd1);
    check("arst_we",      {43'd0, we_o},    44'd0);
    check("arst_addr",    {32'd0, addr_o},  44'd0);
    check("arst_wdata",   {12'd0, wdata_o}, 44'd0);
    check("arst_flags",   {42'd0, done_o, err_o}, 44'd0);
    check("arst_writes_left", 44'(exp_q.size()), 44'd0);
    @(posedge clk_i);
    #1;
    tick(1);
    rst_ni = 1'b1;
    tick(2);
    check("post_rst_idle", {43'd0, reset_o}, 44'd1);
    stream.delete();
    put_hdr(1);
    put_word(32'hCAFEF00D);
    stream.push_back(8'hC9);
    o = model_load();
    check("model_post_rst_outcome", 44'(o), 44'd1);
    check("model_post_rst_w0", exp_q[0], {12'd0, 32'hCAFEF00D});
    run_case("post_rst", o);
    finish_prog("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
